// File: rtl/ahtbe_throttle_tx.sv
// Telemetry transmit stage: sample FIFO feeding a registered valid/ready output,
// rate-limited by backpressure. Define AHTBE_TX_DROP_OLDEST_EN to keep newest data on overflow.
module ahtbe_throttle_tx #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int GAP    = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     backpressure,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     throttled
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int GC_W  = $clog2(GAP + 1);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [GC_W-1:0]  GAP_LD   = GC_W'(GAP);

    typedef enum logic {
        FREE     = 1'b0,
        THROTTLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [GC_W-1:0]     gap_q, gap_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic hs;
    logic fifo_empty;
    logic fifo_full;
    logic gap_open;
    logic pop;
    logic overflow;
    logic mem_we;
    logic discard;
    logic rd_adv;

    always_comb begin
        hs         = out_valid_q & out_ready;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == FULL_LVL);
        // Gap of 1 expires this cycle, so the reload lands exactly GAP idle cycles after the handshake.
        gap_open   = (gap_q <= GC_W'(1));
        pop        = (~out_valid_q | hs) & ~fifo_empty & gap_open
                   & ~(hs & (state_q == THROTTLE));
        overflow   = in_valid & fifo_full & ~pop;
`ifdef AHTBE_TX_DROP_OLDEST_EN
        mem_we     = in_valid;
        discard    = overflow;
`else
        mem_we     = in_valid & ~overflow;
        discard    = 1'b0;
`endif
        rd_adv     = pop | discard;
    end

    always_comb begin
        wr_ptr_d = mem_we ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_adv ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (mem_we && !rd_adv) begin
            level_d = level_q + LVL_W'(1);
        end else if (!mem_we && rd_adv) begin
            level_d = level_q - LVL_W'(1);
        end

        drop_d = drop_q;
        if (overflow && !(&drop_q)) begin
            drop_d = drop_q + CNT_W'(1);
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_q];
        end else if (hs) begin
            out_valid_d = 1'b0;
        end
    end

    // A handshake keeps the FSM throttled so the gap it starts is reported as throttled.
    always_comb begin
        gap_d = gap_q;
        if (hs && state_q == THROTTLE) begin
            gap_d = GAP_LD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GC_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            FREE: begin
                if (backpressure) begin
                    state_d = THROTTLE;
                end
            end
            THROTTLE: begin
                if (!backpressure && gap_q == '0 && !hs) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FREE;
            gap_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            drop_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign fifo_level = level_q;
    assign drop_count = drop_q;
    assign throttled  = (state_q == THROTTLE);

endmodule

// File: tb/tb_ahtbe_throttle_tx.sv
// Self-checking bench for ahtbe_throttle_tx: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ahtbe_throttle_tx;

    localparam int DATA_W  = 16;
    localparam int DEPTH   = 8;
    localparam int GAP     = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   backpressure;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [CNT_W-1:0]       drop_count;
    logic                   throttled;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: FIFO contents as a queue, gap expressed as cycle timestamps.
    logic [DATA_W-1:0] m_q [$];
    bit                m_ov;
    logic [DATA_W-1:0] m_od;
    int                m_drop;
    bit                m_thr;
    int                m_pop_ok;
    int                m_zero_from;

    always #5 clk = ~clk;

    ahtbe_throttle_tx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP    (GAP),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .backpressure (backpressure),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .throttled    (throttled)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic modelStep();
        bit                hs;
        bit                pop;
        bit                full;
        bit                next_thr;
        logic [DATA_W-1:0] head;
        logic [DATA_W-1:0] lost;
        if (!rst_n) begin
            m_q.delete();
            m_ov        = 1'b0;
            m_od        = '0;
            m_drop      = 0;
            m_thr       = 1'b0;
            m_pop_ok    = 0;
            m_zero_from = 0;
            return;
        end
        head = '0;
        hs   = m_ov && out_ready;
        full = (m_q.size() == DEPTH);
        pop  = (!m_ov || hs) && (m_q.size() > 0) && (cyc >= m_pop_ok) && !(hs && m_thr);
        if (pop) head = m_q.pop_front();
        if (in_valid) begin
            if (!full || pop) begin
                m_q.push_back(in_data);
            end else begin
                if (m_drop < CNT_MAX) m_drop++;
`ifdef AHTBE_TX_DROP_OLDEST_EN
                lost = m_q.pop_front();
                m_q.push_back(in_data);
`else
                lost = in_data;
`endif
            end
        end
        if (pop) begin
            m_ov = 1'b1;
            m_od = head;
        end else if (hs) begin
            m_ov = 1'b0;
        end
        if (!m_thr) next_thr = backpressure;
        else        next_thr = !(!backpressure && cyc >= m_zero_from && !hs);
        if (hs && m_thr) begin
            m_pop_ok    = cyc + GAP;
            m_zero_from = cyc + GAP + 1;
        end
        m_thr = next_thr;
    endtask

    task automatic checkOutput();
        check("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        check("throttled", 32'(throttled), 32'(m_thr));
    endtask

    task automatic applyStimulus(input bit r, input bit iv, input logic [DATA_W-1:0] d,
                                 input bit bp, input bit rdy);
        rst_n        = r;
        in_valid     = iv;
        in_data      = d;
        backpressure = bp;
        out_ready    = rdy;
        modelStep();
        @(posedge clk);
        #1;
        cyc++;
        checkOutput();
    endtask

    task automatic checkResetLiterals(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        check({tag, "_drop_count"}, 32'(drop_count), 32'd0);
        check({tag, "_throttled"}, 32'(throttled), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] got_drain [$];
        logic [DATA_W-1:0] exp_drain [9];
        logic [DATA_W-1:0] held;
        int                hs_at [$];
        bit                bp_r;

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        backpressure = 1'b0;
        out_ready    = 1'b0;

        applyStimulus(0, 0, '0, 0, 0);
        applyStimulus(0, 1, 16'hAAAA, 1, 1);
        checkResetLiterals("reset");

        // Back-to-back stream in FREE: words appear on consecutive cycles two cycles after the first write.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, i < 5, DATA_W'(i + 1), 0, 1);
            if (i == 0) check("latency_level", 32'(fifo_level), 32'd1);
            if (i >= 1 && i <= 5) begin
                check("stream_valid", 32'(out_valid), 32'd1);
                check("stream_data", 32'(out_data), 32'(i));
            end
        end

        // Reset while a word is presented and others are buffered.
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, DATA_W'(16'h0200 + i), 0, 0);
        applyStimulus(0, 1, 16'h0300, 0, 0);
        checkResetLiterals("midreset");

        // Throttled emission: handshakes spaced GAP+1 cycles apart.
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, DATA_W'(16'h0A00 + i), 1, 0);
        applyStimulus(1, 0, '0, 1, 0);
        applyStimulus(1, 0, '0, 1, 0);
        check("thr_preload_level", 32'(fifo_level), 32'd4);
        for (int j = 0; j < 26; j++) begin
            if (out_valid) begin
                hs_at.push_back(j);
                check("thr_throttled", 32'(throttled), 32'd1);
            end
            applyStimulus(1, 0, '0, 1, 1);
        end
        check("thr_hs_count", 32'(hs_at.size()), 32'd5);
        for (int i = 1; i < hs_at.size(); i++) begin
            check("thr_spacing", 32'(hs_at[i] - hs_at[i-1]), 32'(GAP + 1));
        end

        // Overflow with the output stalled.
        applyStimulus(0, 0, '0, 0, 0);
        for (int i = 0; i < 11; i++) applyStimulus(1, 1, DATA_W'(16'h0010 + i), 0, 0);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_drop", 32'(drop_count), 32'd2);
        check("ovf_out_data", 32'(out_data), 32'h10);
        exp_drain[0] = 16'h0010;
        for (int i = 1; i < 9; i++) begin
`ifdef AHTBE_TX_DROP_OLDEST_EN
            exp_drain[i] = DATA_W'(16'h0012 + i);
`else
            exp_drain[i] = DATA_W'(16'h0010 + i);
`endif
        end
        for (int j = 0; j < 20; j++) begin
            if (out_valid) got_drain.push_back(out_data);
            applyStimulus(1, 0, '0, 0, 1);
        end
        check("drain_count", 32'(got_drain.size()), 32'd9);
        for (int i = 0; i < 9 && i < got_drain.size(); i++) begin
            check("drain_data", 32'(got_drain[i]), 32'(exp_drain[i]));
        end

        // Stalled word while backpressure toggles, then release.
        applyStimulus(0, 0, '0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, DATA_W'(16'h0B00 + i), 0, 0);
        held = out_data;
        applyStimulus(1, 0, '0, 1, 0);
        applyStimulus(1, 0, '0, 1, 0);
        applyStimulus(1, 0, '0, 0, 0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(held));
        for (int j = 0; j < 16; j++) applyStimulus(1, 0, '0, j < 1, 1);

        // Drop counter saturation.
        applyStimulus(0, 0, '0, 0, 0);
        for (int i = 0; i < 310; i++) applyStimulus(1, 1, DATA_W'(i), 0, 0);
        check("sat_drop", 32'(drop_count), 32'd255);
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, DATA_W'(i), 0, 0);
        check("sat_hold", 32'(drop_count), 32'd255);

        // Randomized traffic with occasional resets.
        applyStimulus(0, 0, '0, 0, 0);
        bp_r = 1'b0;
        for (int j = 0; j < 3000; j++) begin
            if ($urandom_range(15) == 0) bp_r = ~bp_r;
            applyStimulus($urandom_range(299) != 0, $urandom_range(1) == 1,
                          DATA_W'($urandom), bp_r, $urandom_range(9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
